// File: rtl/aludec_pipe.sv
// Registered ALU control decoder with valid/ready handshake.
// Sequences DIV as DIV_STEPS beats and flags illegal encodings.
module aludec_pipe #(
  parameter int OPW       = 4,
  parameter int CTRLW     = 4,
  parameter int DIV_STEPS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [1:0]       aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CTRLW-1:0] alucontrol,
  output logic [3:0]       div_step,
  output logic             div_last,
  output logic             illegal
);

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_NOR   = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_MOVZ  = 4'd5;
  localparam logic [3:0] OP_LSL   = 4'd6;
  localparam logic [3:0] OP_LSR   = 4'd7;
  localparam logic [3:0] OP_DIV   = 4'd8;
  localparam logic [3:0] OP_SLT   = 4'd9;
  localparam logic [3:0] OP_LOAD  = 4'd10;
  localparam logic [3:0] OP_STORE = 4'd11;
  localparam logic [3:0] OP_ADDI  = 4'd12;
  localparam logic [3:0] OP_SUBI  = 4'd13;

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b0001;
  localparam logic [3:0] C_AND  = 4'b0010;
  localparam logic [3:0] C_OR   = 4'b0011;
  localparam logic [3:0] C_MOVZ = 4'b0100;
  localparam logic [3:0] C_DIV  = 4'b0101;
  localparam logic [3:0] C_SLT  = 4'b0110;
  localparam logic [3:0] C_NOR  = 4'b0111;
  localparam logic [3:0] C_LSL  = 4'b1000;
  localparam logic [3:0] C_LSR  = 4'b1001;

  localparam logic [3:0] LAST = 4'(DIV_STEPS - 1);

  logic [31:0] opx;
  logic        op_hi;
  logic [3:0]  op_lo;
  logic [3:0]  dec_ctrl;
  logic        dec_ill;
  logic        dec_div;
  logic        accept;
  logic        div_active;

  // Opcodes wider than 4 bits are illegal whenever any upper bit is set.
  assign opx   = 32'(op);
  assign op_hi = |opx[31:4];
  assign op_lo = opx[3:0];

  always_comb begin
    dec_ctrl = C_ADD;
    dec_ill  = 1'b0;
    dec_div  = 1'b0;
    unique case (aluop)
      2'b00: begin
        if (!op_hi && (op_lo == OP_LOAD ||
                       op_lo == OP_STORE ||
                       op_lo == OP_ADDI)) begin
          dec_ctrl = C_ADD;
        end else if (!op_hi && op_lo == OP_SUBI) begin
          dec_ctrl = C_SUB;
        end else begin
          dec_ctrl = 4'b0000;
          dec_ill  = 1'b1;
        end
      end
      2'b01: dec_ctrl = C_SUB;
      2'b10: begin
        if (op_hi) begin
          dec_ctrl = 4'b0000;
          dec_ill  = 1'b1;
        end else begin
          case (op_lo)
            OP_AND:  dec_ctrl = C_AND;
            OP_OR:   dec_ctrl = C_OR;
            OP_NOR:  dec_ctrl = C_NOR;
            OP_ADD:  dec_ctrl = C_ADD;
            OP_SUB:  dec_ctrl = C_SUB;
            OP_MOVZ: dec_ctrl = C_MOVZ;
            OP_LSL:  dec_ctrl = C_LSL;
            OP_LSR:  dec_ctrl = C_LSR;
            OP_SLT:  dec_ctrl = C_SLT;
            OP_DIV: begin
              dec_ctrl = C_DIV;
              dec_div  = 1'b1;
            end
            default: begin
              dec_ctrl = 4'b0000;
              dec_ill  = 1'b1;
            end
          endcase
        end
      end
      default: begin
        dec_ctrl = 4'b0000;
        dec_ill  = 1'b1;
      end
    endcase
  end

  assign in_ready = !flush &&
                    (!out_valid || (out_ready && div_last));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      alucontrol <= '0;
      div_step   <= '0;
      div_last   <= 1'b0;
      illegal    <= 1'b0;
      div_active <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      div_active <= 1'b0;
      div_step   <= '0;
      div_last   <= 1'b0;
      illegal    <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      alucontrol <= CTRLW'(dec_ctrl);
      div_step   <= '0;
      div_last   <= !dec_div || (LAST == 4'd0);
      illegal    <= dec_ill;
      div_active <= dec_div;
    end else if (out_valid && out_ready) begin
      if (div_active && !div_last) begin
        div_step <= div_step + 4'd1;
        div_last <= (div_step + 4'd1) == LAST;
      end else begin
        out_valid  <= 1'b0;
        div_active <= 1'b0;
        div_step   <= '0;
      end
    end
  end

endmodule

// File: doc/aludec_pipe.md
Name: aludec_pipe

Overview:
Registered, parametrised ALU control decoder for the 4-bit CPU datapath. It replaces the combinational decoder and sits between the main decoder and the ALU. It accepts {op, aluop} via a valid/ready handshake and emits a registered alucontrol word. It sequences DIV as a multi-beat operation, one ALU control beat per divide step, and flags illegal encodings.

Parameters:
OPW, 4, opcode width; opcode values below are fixed, and upper opcode space above 15 is illegal.
CTRLW, 4, alucontrol width; must be at least 4, and upper bits are driven 0.
DIV_STEPS, 4, number of beats issued for DIV; range 1..16.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; drops the held output and aborts any DIV sequence
in_valid  in  1  upstream presents op/aluop
in_ready  out  1  block can accept this cycle
op  in  OPW  instruction opcode
aluop  in  2  main-decoder class: 00 imm/mem, 01 branch, 10 R-type, 11 reserved
out_valid  out  1  alucontrol beat valid
out_ready  in  1  ALU consumes the beat
alucontrol  out  CTRLW  ALU operation code
div_step  out  4  DIV beat index, 0..DIV_STEPS-1; 0 for non-DIV
div_last  out  1  final beat of the op; 1 for every non-DIV beat
illegal  out  1  decode error flag, qualified by out_valid

Behaviour:
- Reset (async, reset_n=0): out_valid=0, alucontrol=0, div_step=0, div_last=0, illegal=0, internal div_active=0. in_ready is 1 once reset deasserts.
- Opcodes: AND=0, OR=1, NOR=2, ADD=3, SUB=4, MOVZ=5, LSL=6, LSR=7, DIV=8, SLT=9, LOAD=10, STORE=11, ADDI=12, SUBI=13, BEQ=14, B=15.
- ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, MOVZ 0100, DIV 0101, SLT 0110, NOR 0111, LSL 1000, LSR 1001. Codes are unique; NOR must not alias AND.
- aluop=00:
  - LOAD, STORE, ADDI map to ADD.
  - SUBI maps to SUB.
  - Any other op: illegal=1, alucontrol=0000.
- aluop=01: SUB for any op (BEQ compare).
- aluop=10:
  - op 0..9 map to the R-type table.
  - op 10..15 or above: illegal=1, alucontrol=0000.
- aluop=11: illegal=1, alucontrol=0000.
- Accept condition: in_valid && in_ready. Latency is 1 cycle: the beat is visible on out_valid the cycle after the accept edge.
- in_ready = !out_valid || (out_ready && div_last). It is combinational from out_ready; no path from in_valid.
- Hold: while out_valid && !out_ready, alucontrol, div_step, div_last and illegal are stable.
- Non-DIV accept: out_valid=1, div_step=0, div_last=1.
- DIV accept (aluop=10, op=8):
  - First beat: div_active=1, div_step=0, div_last=(DIV_STEPS==1).
  - Each consumed beat with div_last=0 advances div_step by 1; alucontrol stays 0101 and out_valid stays 1.
  - div_last=1 when div_step==DIV_STEPS-1.
- Back-to-back: on the cycle a div_last beat is consumed, a new input may be accepted. There are no bubbles, so sustained throughput is 1 op per cycle for non-DIV ops.
- Consumed beat with no new accept: out_valid goes to 0 next cycle.
- flush:
  - Next cycle: out_valid=0, div_active=0, div_step=0.
  - flush has priority over a simultaneous accept; the input is not taken.
  - in_ready is forced 0 while flush=1.
- Illegal ops are single-beat and do not stall or trap; handling them is the upstream's job.
- Reset mid-DIV: the sequence is abandoned immediately, with no residual beats after reset release.

Test Plan:
1. Reset with reset_n=0 mid-cycle → all outputs 0 asynchronously. After release, in_ready=1 and out_valid=0.
2. Stream ADD, SUB, AND, OR, NOR, MOVZ, SLT, LSL, LSR (aluop=10) with out_ready=1 → one beat each, consecutive cycles, codes 0000,0001,0010,0011,0111,0100,0110,1000,1001, div_last=1, illegal=0.
3. DIV with DIV_STEPS=4, out_ready=1, in_valid held with ADDI behind it → 4 beats of 0101 with div_step 0,1,2,3 and div_last only on step 3. in_ready=0 for 3 cycles. ADDI (0000) follows on the next cycle.
4. out_ready=0 for 3 cycles on a DIV beat at step 1 → outputs frozen at step 1 and in_ready=0. Sequence resumes at step 2 when out_ready=1.
5. aluop=11 with op=3, aluop=10 with op=12, and aluop=00 with op=0 → each gives illegal=1, alucontrol=0000, single beat. aluop=01 with op=14 gives 0001.
6. flush at DIV step 2 together with in_valid=1 → out_valid=0 next cycle, input not accepted, div_step=0. The following accept decodes normally.
